// File: rtl/valet_pkg.sv
// Shared types for the valet request sequencer: FSM state encoding and response record.
// Pure declarations; no logic, no latency, no backpressure.
package valet_pkg;

  localparam int VALET_ID_W      = 4;
  localparam int VALET_MAX_RETRY = 3;
  localparam int VALET_RETRY_W   = $clog2(VALET_MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  typedef struct packed {
    logic [VALET_ID_W-1:0]    id;
    logic                     ok;
    logic [VALET_RETRY_W-1:0] retries;
  } rsp_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: q advances by one per cycle with inc high, sticks at all-ones.
// One-cycle update latency; clr has priority over inc; no backpressure.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/valet_req_ctrl.sv
// Request sequencer: dispatch one request, wait for ack with timer timeout, retry, respond.
// Request->svc_start 1 cycle, ack->rsp_valid 1 cycle; req_ready low outside IDLE, rsp held until rsp_ready.
module valet_req_ctrl
  import valet_pkg::*;
#(
  parameter  int ID_W      = VALET_ID_W,
  parameter  int MAX_RETRY = 3,
  parameter  int STAT_W    = 8,
  localparam int RETRY_W   = $clog2(MAX_RETRY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [ID_W-1:0]    req_id,
  output logic               req_ready,
  output logic               svc_start,
  output logic [ID_W-1:0]    svc_id,
  input  logic               svc_ack,
  output logic               tmr_en,
  input  logic               tmr_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_ok,
  output logic [RETRY_W-1:0] rsp_retries,
  output logic               stray_ack,
  output logic [STAT_W-1:0]  timeouts_total
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_ok_q, rsp_ok_d;
  logic [RETRY_W-1:0]   rsp_retries_q, rsp_retries_d;
  logic                 stray_q, stray_d;
  logic                 tmo_inc;

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    retry_d       = retry_q;
    rsp_id_d      = rsp_id_q;
    rsp_ok_d      = rsp_ok_q;
    rsp_retries_d = rsp_retries_q;
    tmo_inc       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          id_d    = req_id;
          retry_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT: begin
        // Ack outranks a coincident expiry: the service did answer in time.
        if (svc_ack) begin
          rsp_id_d      = id_q;
          rsp_ok_d      = 1'b1;
          rsp_retries_d = retry_q;
          state_d       = ST_RESP;
        end else if (tmr_done) begin
          tmo_inc = 1'b1;
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            rsp_id_d      = id_q;
            rsp_ok_d      = 1'b0;
            rsp_retries_d = retry_q;
            state_d       = ST_RESP;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: state_d = ST_ISSUE;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign stray_d = svc_ack && (state_q != ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      retry_q       <= '0;
      rsp_id_q      <= '0;
      rsp_ok_q      <= 1'b0;
      rsp_retries_q <= '0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      retry_q       <= retry_d;
      rsp_id_q      <= rsp_id_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_retries_q <= rsp_retries_d;
      stray_q       <= stray_d;
    end
  end

  sat_counter #(
    .WIDTH (STAT_W)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tmo_inc),
    .clr   (1'b0),
    .q     (timeouts_total)
  );

  // Timer is cleared whenever tmr_en drops, so ISSUE and BACKOFF both restart it.
  assign req_ready   = (state_q == ST_IDLE);
  assign svc_start   = (state_q == ST_ISSUE);
  assign svc_id      = id_q;
  assign tmr_en      = (state_q == ST_WAIT);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_retries = rsp_retries_q;
  assign stray_ack   = stray_q;

endmodule
